// File: rtl/tvm_window_pkg.sv
// rtl/tvm_window_pkg.sv - shared FSM state type and sizing helper for the window reader
package tvm_window_pkg;

  // Reader FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SKIP = 2'd2,
    WAIT = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) n = i + 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/tvm_window_reader_if.sv
// rtl/tvm_window_reader_if.sv - buffer-read and pixel-stream bundle for the window reader
// slave  : reader side (drives read_ready/read_addr/read_advance and out_*)
// master : buffer + downstream side (drives read_valid/read_data and out_ready)
interface tvm_window_reader_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int RD_ADDR_WIDTH = 5
);
  logic                     read_valid;
  logic                     read_ready;
  logic [RD_ADDR_WIDTH-1:0] read_addr;
  logic                     read_advance;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;

  modport slave (
    input  read_valid, read_data, out_ready,
    output read_ready, read_addr, read_advance, out_data, out_valid, out_last
  );

  modport master (
    output read_valid, read_data, out_ready,
    input  read_ready, read_addr, read_advance, out_data, out_valid, out_last
  );
endinterface

// File: rtl/tvm_window_skid.sv
// rtl/tvm_window_skid.sv - 2-entry output FIFO carrying pixel data plus last tag
// clk, rst      : clock, synchronous active-high reset
// i_push*       : write strobe, pixel, last tag
// i_pop         : head consumed this cycle
// o_valid/o_data/o_last : FIFO head (data/last forced to 0 while empty)
// o_count       : current occupancy 0..2
module tvm_window_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_push_last,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [1:0]            o_count
);
  logic [DATA_WIDTH:0] r_mem [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                w_pop_ok;
  logic                w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr][DATA_WIDTH-1:0] : '0;
  assign o_last  = o_valid ? r_mem[r_rd_ptr][DATA_WIDTH]     : 1'b0;
  assign o_count = r_count;
endmodule

// File: rtl/tvm_window_reader.sv
// rtl/tvm_window_reader.sv - reads KxK windows out of a line buffer as a pixel stream
// clk, rst : clock, synchronous active-high reset
// bus      : slave side of tvm_window_reader_if
//   read_valid/read_ready/read_addr/read_advance/read_data : line-buffer port
//   out_data/out_valid/out_last/out_ready                  : pixel stream, out_last on K*K-th pixel
module tvm_window_reader
  import tvm_window_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int IMAGE_WIDTH   = 8,
  parameter int KERNEL_WIDTH  = 3,
  parameter int RD_ADDR_WIDTH = 5,
  parameter int SKIP_WRAP     = 1
) (
  input logic               clk,
  input logic               rst,
  tvm_window_reader_if.slave bus
);
  localparam int COL_W = clog2(IMAGE_WIDTH);
  localparam int IDX_W = clog2(KERNEL_WIDTH);
  localparam logic [COL_W-1:0]         LAST_COL      = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0]         MAX_START_COL = COL_W'(IMAGE_WIDTH - KERNEL_WIDTH);
  localparam logic [IDX_W-1:0]         LAST_IDX      = IDX_W'(KERNEL_WIDTH - 1);
  // Address jump from the last column of one window row to the first of the next
  localparam logic [RD_ADDR_WIDTH-1:0] ROW_STEP      = RD_ADDR_WIDTH'(IMAGE_WIDTH - KERNEL_WIDTH + 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [COL_W-1:0]         r_col;
  logic [IDX_W-1:0]         r_row;
  logic [IDX_W-1:0]         r_c;
  logic [RD_ADDR_WIDTH-1:0] r_addr;
  logic                     r_inflight;
  logic                     r_inflight_last;

  logic                     w_issue;
  logic                     w_advance;
  logic                     w_last_elem;
  logic                     w_room;
  logic                     w_start_read;
  logic                     w_pop;
  logic [2:0]               w_occupancy;
  logic                     w_fifo_valid;
  logic [DATA_WIDTH-1:0]    w_fifo_data;
  logic                     w_fifo_last;
  logic [1:0]               w_fifo_count;

  assign w_last_elem  = (r_row == LAST_IDX) && (r_c == LAST_IDX);
  assign w_pop        = w_fifo_valid && bus.out_ready && !rst;
  // Entries the FIFO will hold once this cycle's pop and the in-flight read land;
  // counting the pop lets reads stream back-to-back when downstream keeps up
  assign w_occupancy  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room       = (w_occupancy < 3'd2);
  assign w_start_read = (SKIP_WRAP == 0) || (r_col <= MAX_START_COL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // IDLE already issues element 0 so a window costs K*K+1 cycles including WAIT
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.read_valid) begin
          if (w_start_read) begin
            w_issue      = w_room;
            w_advance    = w_room && w_last_elem;
            w_next_state = (w_room && w_last_elem) ? WAIT : READ;
          end else begin
            w_next_state = SKIP;
          end
        end
      end
      READ: begin
        if (bus.read_valid && w_room) begin
          w_issue = 1'b1;
          if (w_last_elem) begin
            w_advance    = 1'b1;
            w_next_state = WAIT;
          end
        end
      end
      SKIP: begin
        w_advance    = 1'b1;
        w_next_state = WAIT;
      end
      // Gives the buffer a cycle to update read_valid after the pop
      WAIT:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (rst) begin
      w_issue   = 1'b0;
      w_advance = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col           <= '0;
      r_row           <= '0;
      r_c             <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_elem;
      if (w_issue) begin
        if (w_last_elem) begin
          r_row  <= '0;
          r_c    <= '0;
          r_addr <= '0;
        end else if (r_c == LAST_IDX) begin
          r_c    <= '0;
          r_row  <= r_row + IDX_W'(1);
          r_addr <= r_addr + ROW_STEP;
        end else begin
          r_c    <= r_c + IDX_W'(1);
          r_addr <= r_addr + RD_ADDR_WIDTH'(1);
        end
      end
      if (w_advance) r_col <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
    end
  end

  tvm_window_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (bus.read_data),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_last      (w_fifo_last),
    .o_count     (w_fifo_count)
  );

  // Outputs are forced low while rst is held, not just after the reset edge
  assign bus.read_ready   = w_issue;
  assign bus.read_advance = w_advance;
  assign bus.read_addr    = rst ? '0 : r_addr;
  assign bus.out_valid    = w_fifo_valid && !rst;
  assign bus.out_last     = w_fifo_last && !rst;
  assign bus.out_data     = rst ? '0 : w_fifo_data;
endmodule

// File: doc/tvm_window_reader.md
TVM_WINDOW_READER -- requirements
Module: tvm_window_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 8, image row length in pixels.
REQ-003 SHALL have parameter KERNEL_WIDTH, default 3, square window side K.
REQ-004 SHALL have parameter RD_ADDR_WIDTH, default 5, buffer read-address width; must hold (K-1)*IMAGE_WIDTH+K-1.
REQ-005 SHALL have parameter SKIP_WRAP, default 1; 1 = skip windows straddling a row boundary.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port read_valid  input  1  buffer holds a full window.
REQ-009 SHALL have port read_ready  output  1  read request, qualified by read_addr.
REQ-010 SHALL have port read_addr  output  RD_ADDR_WIDTH  window-relative element address.
REQ-011 SHALL have port read_advance  output  1  pop one entry from the buffer.
REQ-012 SHALL have port read_data  input  DATA_WIDTH  buffer data, valid one cycle after read_ready.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  window pixel stream.
REQ-014 SHALL have port out_valid  output  1  out_data valid.
REQ-015 SHALL have port out_last  output  1  final (K*K-th) pixel of a window.
REQ-016 SHALL have port out_ready  input  1  downstream accepts on out_valid&&out_ready.

Function
REQ-017 SHALL use FSM states IDLE, READ, SKIP, WAIT.
REQ-018 SHALL go IDLE->READ when read_valid=1 and column col <= IMAGE_WIDTH-K, or when SKIP_WRAP=0.
REQ-019 SHALL go IDLE->SKIP when read_valid=1, SKIP_WRAP=1 and col > IMAGE_WIDTH-K.
REQ-020 SHALL, in READ, issue addresses r*IMAGE_WIDTH+c, r outer, c inner, r,c in 0..K-1 (K=3, W=8: 0,1,2,8,9,10,16,17,18).
REQ-021 SHALL assert read_ready only when read_valid=1 and fifo_count+inflight < 2; otherwise hold read_addr and element index.
REQ-022 SHALL assert read_advance for exactly one cycle, together with the last element read of the window in READ, or alone in SKIP.
REQ-023 SHALL go READ->WAIT and SKIP->WAIT after read_advance, and WAIT->IDLE after exactly one cycle, so buffer read_valid is resampled.
REQ-024 SHALL increment col modulo IMAGE_WIDTH on each read_advance.
REQ-025 SHALL push read_data into a 2-entry output FIFO on the cycle after each read_ready, tagging the last element with out_last.
REQ-026 SHALL drive out_data/out_valid/out_last from the FIFO head; out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 SHALL never drop or duplicate a pixel; with FIFO full and one read in flight, no new read_ready.
REQ-028 SHALL support simultaneous FIFO push and pop without a bubble.
REQ-029 SHALL hold throughput at K*K+1 cycles per window with read_valid=1 and out_ready=1.
REQ-030 SHALL, if read_valid drops mid-window, stall the read sequence and resume at the next element.

Reset
REQ-031 SHALL on rst clear: state=IDLE, col=0, element index=0, FIFO empty, inflight=0.
REQ-032 SHALL drive read_ready=0, read_advance=0, read_addr=0, out_valid=0, out_last=0, out_data=0 during and after reset.
REQ-033 SHALL, on reset mid-window, discard in-flight data; first post-reset read is address 0.

Structure
REQ-034 SHALL place the FSM state enum and a ceil-log2 helper in package tvm_window_pkg.
REQ-035 SHALL implement the 2-entry output FIFO as sub-module tvm_window_skid.

Verification
REQ-036 SHALL test: buffer preloaded 0,1,2,... (W=8, K=3), out_ready=1 -> out 0,1,2,8,9,10,16,17,18, out_last on 18, one read_advance.
REQ-037 SHALL test: SKIP_WRAP=1, run 8 advances -> windows col 0..5 emitted (first pixels 0..5), col 6,7 each one advance and no output, 9th window first pixel 8.
REQ-038 SHALL test: out_ready=0 for 6 cycles mid-window -> at most 2 pending pixels, read_ready low, sequence complete without loss once out_ready=1.
REQ-039 SHALL test: read_valid deasserted after 4th element for 3 cycles -> stall, next address 9, full window correct.
REQ-040 SHALL test: rst pulse after 5th element -> all outputs 0 next cycle, new window starts at address 0, col=0.
REQ-041 SHALL test: SKIP_WRAP=0 -> col 6 window emitted as 6,7,8,14,15,16,22,23,24.
